// File: rtl/shift_seq8.sv
// rtl/shift_seq8.sv - 8-bit multi-cycle shifter/rotator, at most 3 bit positions per cycle
//
// Purpose:
//   Accepts an operand, an operation and a total shift amount (0..7) on a start
//   pulse in IDLE. It then shifts the working register by up to 3 positions per
//   cycle until the full amount has been applied. It presents a one-cycle done
//   pulse and holds the result until the next accepted start.
//
// Ports:
//   clk_i      system clock, all state updates on the rising edge
//   reset_i    asynchronous active-high reset
//   start_i    request pulse, only looked at in IDLE
//   op_i       00 LSL, 01 LSR, 10 ASR, 11 ROR
//   amount_i   total shift amount 0..7
//   d_in_i     operand, captured when start is accepted
//   busy_o     high whenever the FSM is not in IDLE
//   done_o     one-cycle completion pulse (FSM in DONE)
//   d_out_o    working/result register
module shift_seq8 (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [1:0] op_i,
  input  logic [2:0] amount_i,
  input  logic [7:0] d_in_i,
  output logic       busy_o,
  output logic       done_o,
  output logic [7:0] d_out_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [2:0] remaining_q, remaining_d;
  logic [7:0] data_q, data_d;

  logic [1:0] step;
  logic [2:0] remaining_after;
  logic [7:0] shifted;

  // Apply one step of the latched operation. ROR shifts a doubled copy, so
  // that the bits leaving bit 0 re-enter at bit 7.
  function automatic logic [7:0] shift_step(input logic [7:0] data,
                                            input logic [1:0] op,
                                            input logic [1:0] amt);
    logic [15:0] dbl;
    logic [7:0]  res;
    dbl = {data, data} >> amt;
    case (op)
      OP_LSL:  res = data << amt;
      OP_LSR:  res = data >> amt;
      OP_ASR:  res = $unsigned($signed(data) >>> amt);
      OP_ROR:  res = dbl[7:0];
      default: res = data;
    endcase
    return res;
  endfunction

  // Remaining is 0..7, so the step never exceeds it and the 3-bit
  // subtraction cannot wrap.
  always_comb begin
    step            = (remaining_q > 3'd3) ? 2'd3 : remaining_q[1:0];
    remaining_after = remaining_q - {1'b0, step};
    shifted         = shift_step(data_q, op_q, step);
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          data_d      = d_in_i;
          op_d        = op_i;
          remaining_d = amount_i;
          state_d     = (amount_i != 3'd0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        data_d      = shifted;
        remaining_d = remaining_after;
        if (remaining_after == 3'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_LSL;
      remaining_q <= 3'd0;
      data_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // Both outputs decode the state register directly, so reset clears them
  // without waiting for a clock edge.
  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_DONE);
  assign d_out_o = data_q;

endmodule

// File: tb/tb_shift_seq8.sv
// tb/tb_shift_seq8.sv - randomized self-checking bench for shift_seq8
module tb_shift_seq8;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [1:0] op_i = 2'b00;
  logic [2:0] amount_i = 3'd0;
  logic [7:0] d_in_i = 8'h00;
  logic       busy_o;
  logic       done_o;
  logic [7:0] d_out_o;

  int n_cmp = 0;
  int n_bad = 0;

  shift_seq8 dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .amount_i (amount_i),
    .d_in_i   (d_in_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .d_out_o  (d_out_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the whole shift applied at once with plain integer arithmetic.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [1:0] op, input int a);
    int v;
    v = d;
    case (op)
      2'b00: v = (v << a) & 255;
      2'b01: v = v >> a;
      2'b10: v = (((v >= 128) ? v - 256 : v) >>> a) & 255;
      default: v = ((v >> a) | (v << (8 - a))) & 255;
    endcase
    return v[7:0];
  endfunction

  // Called at a negedge; issues start there. Returns at the negedge of the
  // IDLE cycle following DONE, so a following call is a back-to-back start.
  // noise scrambles inputs and re-pulses start while the operation is busy.
  task automatic do_op(input logic [1:0] op, input int amt, input logic [7:0] d, input bit noise);
    int  lat;
    int  shown;
    bit  seen;
    logic [7:0] final_v;
    lat     = (amt + 2) / 3 + 1;
    final_v = ref_shift(d, op, amt);
    seen    = 0;
    start_i  = 1'b1;
    op_i     = op;
    amount_i = amt[2:0];
    d_in_i   = d;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      shown = 3 * (c - 1);
      if (shown > amt) shown = amt;
      check("busy", busy_o, 1'b1);
      if (c < lat) begin
        check("done_early", done_o, 1'b0);
        check("d_out_step", d_out_o, ref_shift(d, op, shown));
        if (noise) begin
          start_i  = 1'b1;
          op_i     = $urandom_range(0, 3);
          amount_i = $urandom_range(0, 7);
          d_in_i   = $urandom_range(0, 255);
        end
      end else begin
        check("done", done_o, 1'b1);
        check("d_out_final", d_out_o, final_v);
        seen = 1;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(negedge clk_i);
    check("idle_busy", busy_o, 1'b0);
    check("idle_done", done_o, 1'b0);
    check("d_out_hold", d_out_o, final_v);
  endtask

  initial begin
    int amt;
    #2;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_dout", d_out_o, 8'h00);

    // Release reset with start already high: the first edge must accept it.
    @(negedge clk_i);
    reset_i = 1'b0;
    do_op(2'b00, 7, 8'h81, 0);
    do_op(2'b10, 7, 8'h81, 0);
    do_op(2'b01, 3, 8'h81, 0);
    do_op(2'b11, 4, 8'h81, 0);
    for (int o = 0; o < 4; o++) do_op(o[1:0], 0, 8'hA5, 0);
    do_op(2'b11, 7, 8'h3C, 1);
    do_op(2'b10, 5, 8'h96, 1);

    // Asynchronous reset in the middle of a 7-position shift.
    start_i = 1'b1; op_i = 2'b00; amount_i = 3'd7; d_in_i = 8'hFF;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    check("pre_rst_busy", busy_o, 1'b1);
    #2 reset_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_done", done_o, 1'b0);
    check("arst_dout", d_out_o, 8'h00);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("rst_no_done", done_o, 1'b0);
    end
    reset_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_idle", busy_o, 1'b0);
    do_op(2'b01, 6, 8'hC3, 0);

    // Random traffic with random idle gaps and occasional busy-time noise.
    for (int i = 0; i < 60; i++) begin
      amt = $urandom_range(0, 7);
      do_op($urandom_range(0, 3), amt, $urandom_range(0, 255), $urandom_range(0, 1));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        op_i = $urandom_range(0, 3);
        d_in_i = $urandom_range(0, 255);
        @(negedge clk_i);
        check("gap_idle", busy_o, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_seq8.md
SHIFT_SEQ8 -- requirements
Module: shift_seq8

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 bits, per-step shift limit is fixed at 3.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 amount  input  3  total shift amount, 0..7.
REQ-007 d_in  input  8  operand, captured on accepted start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 d_out  output  8  working/result register, registered output.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL, at that edge, load d_out<=d_in, latch op and amount into internal registers (remaining<=amount), and go to SHIFT if amount!=0, else go to DONE.
REQ-013 start in SHIFT or DONE SHALL be ignored; op, amount, d_in changes after acceptance SHALL NOT affect the operation in progress.
REQ-014 Each SHIFT cycle SHALL apply step=min(remaining,3) using latched op, and SHALL set remaining<=remaining-step.
REQ-015 LSL step SHALL zero-fill LSBs; LSR step SHALL zero-fill MSBs; ASR step SHALL replicate bit 7; ROR step SHALL rotate bits 0 into 7.
REQ-016 SHIFT SHALL transition to DONE on the cycle where remaining-step==0, otherwise stay in SHIFT.
REQ-017 DONE SHALL assert done=1 for exactly that one cycle and return to IDLE on the next edge.
REQ-018 Latency: done SHALL be high in cycle N+1 after the accepting edge, N=ceil(amount/3) (amount 0 -> 1 cycle, 1..3 -> 2, 4..6 -> 3, 7 -> 4).
REQ-019 busy SHALL be high in SHIFT and DONE, low in IDLE; a new start SHALL be accepted in the cycle immediately after DONE.
REQ-020 d_out SHALL hold its final value from DONE until the next accepted start; intermediate values during SHIFT are visible but not valid.
REQ-021 amount=0 SHALL pass d_in unchanged for all four ops.
REQ-022 All arithmetic on remaining SHALL be 3-bit unsigned; remaining SHALL never underflow.

Reset
REQ-023 reset=1 SHALL immediately, independent of clk, force state=IDLE, d_out=8'h00, busy=0, done=0, remaining=0, latched op=00.
REQ-024 reset asserted mid-SHIFT or in DONE SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-025 start coincident with the first edge after reset release SHALL be accepted.

Verification
REQ-026 d_in=8'h81, op=LSL, amount=7, start -> busy 4 cycles, done in cycle 4, d_out=8'h80.
REQ-027 d_in=8'h81, op=ASR, amount=7 -> d_out=8'hFF; op=LSR, amount=3 -> done in cycle 2, d_out=8'h10.
REQ-028 d_in=8'h81, op=ROR, amount=4 -> intermediate 8'h30, final d_out=8'h18, done in cycle 3.
REQ-029 d_in=8'hA5, any op, amount=0 -> done in cycle 1, d_out=8'hA5, busy high one cycle.
REQ-030 start re-pulsed with new d_in while busy -> ignored, result matches original operand; back-to-back start right after DONE accepted.
REQ-031 reset pulsed asynchronously mid-SHIFT (amount=7) -> outputs 0 immediately, no done pulse, next operation correct.
